// File: rtl/ldpc_dec_pkg.sv
//------------------------------------------------------------------------------
// Module   : ldpc_dec_pkg
// Brief    : Shared constants, state type and hard-decision helper.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ldpc_dec_pkg;

  localparam int c_def_lanes = 32;
  localparam int c_def_llr_w = 6;
  localparam int c_def_depth = 128;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } asm_state_t;

  // Only the LLR sign carries the decision, so callers pass the MSB.
  function automatic logic hard_bit(input logic llr_sign, input logic inv);
    return llr_sign ^ inv;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hd_lane_slice.sv
//------------------------------------------------------------------------------
// Module   : hd_lane_slice
// Brief    : DEPTH-bit hard-decision row store for one lane.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hd_lane_slice
  import ldpc_dec_pkg::*;
#(
  parameter int DEPTH  = c_def_depth,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic              bit_in,
  output logic [DEPTH-1:0]  bits
);

  logic [DEPTH-1:0] r_bits;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_bits <= '0;
    end else if (we) begin
      r_bits[addr] <= bit_in;
    end
  end

  assign bits = r_bits;

endmodule

`default_nettype wire

// File: rtl/hd_frame_assembler.sv
//------------------------------------------------------------------------------
// Module   : hd_frame_assembler
// Brief    : Collects LLR sign bits into a LANES*DEPTH hard-decision frame.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hd_frame_assembler
  import ldpc_dec_pkg::*;
#(
  parameter int LANES    = c_def_lanes,
  parameter int LLR_W    = c_def_llr_w,
  parameter int DEPTH    = c_def_depth,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int SIGN_INV = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*LLR_W-1:0] in_llr,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic                   in_last,
  input  logic                   abort,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*DEPTH-1:0] out_data,
  output logic [ADDR_W:0]        out_beats,
  output logic                   err_dup
);

  localparam logic [ADDR_W:0] c_depth    = (ADDR_W+1)'(DEPTH);
  localparam logic            c_sign_inv = (SIGN_INV != 0);

  asm_state_t       r_state;
  logic [DEPTH-1:0] r_mask;
  logic [ADDR_W:0]  r_count;
  logic             r_err_dup;

  logic w_accept;
  logic w_in_range;
  logic w_row_used;
  logic w_handoff;
  logic w_clear;
  logic w_we;

  assign in_ready   = rst_n & (r_state == COLLECT);
  assign out_valid  = (r_state == HOLD);
  assign out_beats  = r_count;
  assign err_dup    = r_err_dup;

  assign w_accept   = in_valid & in_ready;
  assign w_in_range = ({1'b0, in_addr} < c_depth);
  assign w_row_used = w_in_range & r_mask[in_addr];
  assign w_handoff  = out_valid & out_ready;
  // Abort outranks both a write and a handoff on the same edge.
  assign w_clear    = ~rst_n | abort | w_handoff;
  assign w_we       = w_accept & w_in_range & ~abort;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic w_hard;

    assign w_hard = hard_bit(in_llr[k*LLR_W + LLR_W-1], c_sign_inv);

    hd_lane_slice #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_slice (
      .clk    (clk),
      .clr    (w_clear),
      .we     (w_we),
      .addr   (in_addr),
      .bit_in (w_hard),
      .bits   (out_data[k*DEPTH +: DEPTH])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= COLLECT;
      r_mask    <= '0;
      r_count   <= '0;
      r_err_dup <= 1'b0;
    end else begin
      r_err_dup <= 1'b0;
      if (abort) begin
        r_state <= COLLECT;
        r_mask  <= '0;
        r_count <= '0;
      end else begin
        case (r_state)
          COLLECT: begin
            if (w_accept) begin
              if (w_in_range) begin
                r_mask[in_addr] <= 1'b1;
                if (w_row_used) begin
                  r_err_dup <= 1'b1;
                end else begin
                  r_count <= r_count + (ADDR_W+1)'(1);
                end
              end
              if (in_last) begin
                r_state <= HOLD;
              end
            end
          end
          HOLD: begin
            if (out_ready) begin
              r_state <= COLLECT;
              r_mask  <= '0;
              r_count <= '0;
            end
          end
          default: r_state <= COLLECT;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hd_frame_assembler.sv
//------------------------------------------------------------------------------
// Module   : tb_hd_frame_assembler
// Brief    : Self-checking bench for hd_frame_assembler (normal and inverted sign).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hd_frame_assembler;

  localparam int LANES  = 4;
  localparam int LLR_W  = 6;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef struct {
    string           name;
    int              n;
    logic [7:0][2:0] addr;
    logic [7:0][3:0] neg;
    logic [31:0]     exp_data;
    logic [31:0]     exp_inv;
    int              exp_beats;
    int              exp_dups;
  } frame_vec_t;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic [LANES*LLR_W-1:0] in_llr;
  logic [ADDR_W-1:0]      in_addr;
  logic                   in_last;
  logic                   abort;
  logic                   out_ready;

  logic                   in_ready,  inv_in_ready;
  logic                   out_valid, inv_out_valid;
  logic [LANES*DEPTH-1:0] out_data,  inv_out_data;
  logic [ADDR_W:0]        out_beats, inv_out_beats;
  logic                   err_dup,   inv_err_dup;

  int n_checks;
  int n_pass;

  hd_frame_assembler #(
    .LANES(LANES), .LLR_W(LLR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SIGN_INV(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_llr(in_llr), .in_addr(in_addr), .in_last(in_last), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .err_dup(err_dup)
  );

  hd_frame_assembler #(
    .LANES(LANES), .LLR_W(LLR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SIGN_INV(1)
  ) u_inv (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inv_in_ready),
    .in_llr(in_llr), .in_addr(in_addr), .in_last(in_last), .abort(abort),
    .out_valid(inv_out_valid), .out_ready(out_ready), .out_data(inv_out_data),
    .out_beats(inv_out_beats), .err_dup(inv_err_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Lane k negative when (addr+k) is odd.
  function automatic logic [3:0] pat(input int a);
    logic [3:0] p;
    for (int k = 0; k < LANES; k++) p[k] = ((a + k) % 2) == 1;
    return p;
  endfunction

  function automatic logic [LANES*LLR_W-1:0] make_llr(input logic [3:0] neg);
    logic [LANES*LLR_W-1:0] v;
    for (int k = 0; k < LANES; k++)
      v[k*LLR_W +: LLR_W] = {neg[k], 5'($urandom)};
    return v;
  endfunction

  // Reference: last write per row wins; unwritten rows are zero.
  task automatic model(input int n, input logic [7:0][2:0] addr, input logic [7:0][3:0] neg,
                       output logic [31:0] ed, output logic [31:0] ei,
                       output int eb, output int edup);
    logic [7:0]      wr;
    logic [7:0][3:0] rows;
    wr = '0; rows = '0; edup = 0; ed = '0; ei = '0;
    for (int i = 0; i < n; i++) begin
      if (wr[addr[i]]) edup++;
      wr[addr[i]]   = 1'b1;
      rows[addr[i]] = neg[i];
    end
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < LANES; k++)
        if (wr[r]) begin
          ed[k*DEPTH + r] = rows[r][k];
          ei[k*DEPTH + r] = ~rows[r][k];
        end
    eb = $countones(wr);
  endtask

  task automatic drive_beat(input logic [2:0] a, input logic [3:0] neg, input logic last,
                            input logic ab, output logic dup, output logic dup_inv);
    int t;
    @(negedge clk);
    in_valid = 1'b1; in_addr = a; in_llr = make_llr(neg); in_last = last; abort = ab;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    dup = err_dup; dup_inv = inv_err_dup;
    abort = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; abort = 1'b0; out_ready = 1'b0;
  endtask

  task automatic run_frame(input string name, input int n, input logic [7:0][2:0] addr,
                           input logic [7:0][3:0] neg, input logic [31:0] ed,
                           input logic [31:0] ei, input int eb, input int edup);
    int   dups, dups_i, stall;
    logic d, di;
    dups = 0; dups_i = 0;
    for (int i = 0; i < n; i++) begin
      drive_beat(addr[i], neg[i], (i == n-1), 1'b0, d, di);
      dups += int'(d); dups_i += int'(di);
    end
    check({name, " valid_lat1"}, out_valid, 1);
    idle();
    check({name, " data"},      out_data, ed);
    check({name, " inv_data"},  inv_out_data, ei);
    check({name, " beats"},     out_beats, eb);
    check({name, " inv_beats"}, inv_out_beats, eb);
    check({name, " dups"},      dups, edup);
    check({name, " inv_dups"},  dups_i, edup);
    stall = $urandom_range(0, 3);
    repeat (stall) @(negedge clk);
    check({name, " valid_held"}, out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, " valid_drop"}, out_valid, 0);
    check({name, " ready_back"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  frame_vec_t      vecs[4];
  logic [7:0][2:0] ra;
  logic [7:0][3:0] rn;
  logic [31:0]     m_ed, m_ei;
  int              m_eb, m_edup, rn_n;
  logic            d0, d1;
  int              shuf[8] = '{7, 0, 3, 5, 1, 6, 2, 4};

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_llr = '0; in_addr = '0;
    in_last = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_data",  out_data, 0);
    check("rst out_beats", out_beats, 0);
    check("rst err_dup",   err_dup, 0);
    check("rst in_ready",  in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0].name = "inorder"; vecs[0].n = 8;
    vecs[1].name = "shuffle"; vecs[1].n = 8;
    vecs[3].name = "allneg";  vecs[3].n = 8;
    for (int i = 0; i < 8; i++) begin
      vecs[0].addr[i] = 3'(i);       vecs[0].neg[i] = pat(i);
      vecs[1].addr[i] = 3'(shuf[i]); vecs[1].neg[i] = pat(shuf[i]);
      vecs[3].addr[i] = 3'(i);       vecs[3].neg[i] = 4'hF;
    end
    vecs[0].exp_data = 32'h55AA55AA; vecs[0].exp_inv = 32'hAA55AA55;
    vecs[0].exp_beats = 8; vecs[0].exp_dups = 0;
    vecs[1].exp_data = 32'h55AA55AA; vecs[1].exp_inv = 32'hAA55AA55;
    vecs[1].exp_beats = 8; vecs[1].exp_dups = 0;
    vecs[3].exp_data = 32'hFFFFFFFF; vecs[3].exp_inv = 32'h00000000;
    vecs[3].exp_beats = 8; vecs[3].exp_dups = 0;
    vecs[2].name = "dup"; vecs[2].n = 3;
    vecs[2].addr = '0; vecs[2].neg = '0;
    vecs[2].addr[0] = 3'd2; vecs[2].neg[0] = 4'b0101;
    vecs[2].addr[1] = 3'd2; vecs[2].neg[1] = 4'b1010;
    vecs[2].addr[2] = 3'd5; vecs[2].neg[2] = 4'b1111;
    vecs[2].exp_data = 32'h24202420; vecs[2].exp_inv = 32'h00040004;
    vecs[2].exp_beats = 2; vecs[2].exp_dups = 1;

    for (int v = 0; v < 4; v++)
      run_frame(vecs[v].name, vecs[v].n, vecs[v].addr, vecs[v].neg,
                vecs[v].exp_data, vecs[v].exp_inv, vecs[v].exp_beats, vecs[v].exp_dups);

    // Output stall with input pressure: nothing may enter while HOLD.
    for (int i = 0; i < 8; i++) drive_beat(3'(i), pat(i), (i == 7), 1'b0, d0, d1);
    @(negedge clk);
    in_valid = 1'b1; in_addr = 3'd3; in_llr = make_llr(4'hF); in_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d in_ready", c), in_ready, 0);
      check($sformatf("stall%0d data", c), out_data, 32'h55AA55AA);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall release valid", out_valid, 0);
    check("stall release ready", in_ready, 1);
    check("stall release beats", out_beats, 0);
    idle();

    // Abort together with an accepted beat after three beats.
    for (int i = 0; i < 3; i++) drive_beat(3'(i), 4'hF, 1'b0, 1'b0, d0, d1);
    drive_beat(3'd3, 4'hF, 1'b0, 1'b1, d0, d1);
    check("abort beats", out_beats, 0);
    check("abort data",  out_data, 0);
    check("abort dup",   d0, 0);
    check("abort valid", out_valid, 0);
    idle();
    run_frame("post_abort", vecs[0].n, vecs[0].addr, vecs[0].neg,
              vecs[0].exp_data, vecs[0].exp_inv, vecs[0].exp_beats, vecs[0].exp_dups);

    // Abort in HOLD beats a simultaneous out_ready.
    for (int i = 0; i < 3; i++)
      drive_beat(vecs[2].addr[i], vecs[2].neg[i], (i == 2), 1'b0, d0, d1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; abort = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_abort valid", out_valid, 0);
    check("hold_abort data",  out_data, 0);
    check("hold_abort beats", out_beats, 0);
    idle();

    for (int f = 0; f < 20; f++) begin
      rn_n = 1 + int'($urandom % 8);
      for (int i = 0; i < 8; i++) begin
        ra[i] = 3'($urandom);
        rn[i] = 4'($urandom);
      end
      model(rn_n, ra, rn, m_ed, m_ei, m_eb, m_edup);
      run_frame($sformatf("rnd%0d", f), rn_n, ra, rn, m_ed, m_ei, m_eb, m_edup);
    end

    // Reset pulse while a frame is held.
    for (int i = 0; i < 8; i++) drive_beat(3'(i), pat(i), (i == 7), 1'b0, d0, d1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("hold_rst valid",    out_valid, 0);
    check("hold_rst data",     out_data, 0);
    check("hold_rst beats",    out_beats, 0);
    check("hold_rst inv_data", inv_out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("post_rst_allneg", vecs[3].n, vecs[3].addr, vecs[3].neg,
              vecs[3].exp_data, vecs[3].exp_inv, vecs[3].exp_beats, vecs[3].exp_dups);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
